// File: rtl/lfsr_rng_arbiter.sv
// lfsr_rng_arbiter: one 32-bit Fibonacci LFSR shared round-robin among N_REQ requesters.
// Each grant carries one word and advances the LFSR once; reset/reseed runs a warm-up first.
module lfsr_rng_arbiter #(
  parameter int unsigned N_REQ         = 4,
  parameter logic [31:0] SEED          = 32'h12345678,
  parameter int unsigned WARMUP_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [31:0]      rnd_data,
  input  logic             seed_load,
  input  logic [31:0]      seed_in,
  output logic             busy
);

  localparam int unsigned PW       = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [7:0]  WARM_CNT = 8'(WARMUP_CYCLES);
  localparam logic        WARM_EN  = (WARMUP_CYCLES != 32'd0);

  typedef enum logic [0:0] {
    ST_WARM  = 1'b0,
    ST_SERVE = 1'b1
  } state_e;

  localparam state_e START_ST = WARM_EN ? ST_WARM : ST_SERVE;

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
  endfunction

  state_e           state_q;
  logic [7:0]       cnt_q;
  logic [31:0]      s_q;
  logic [PW-1:0]    ptr_q;
  logic [N_REQ-1:0] gnt_q;
  logic [31:0]      rnd_q;
  logic             busy_q;

  logic [N_REQ-1:0] elig_s;
  logic [N_REQ-1:0] gnt_d;
  logic [PW-1:0]    ptr_d;
  logic             pick_v_s;

  // A requester granted last cycle sits out this cycle so one holder cannot hog words.
  assign elig_s = req & ~gnt_q;

  // Round-robin search starting at ptr_q, wrapping modulo N_REQ.
  always_comb begin
    logic [PW:0] idx_w;
    logic [PW:0] nxt_w;
    logic        hit_w;
    gnt_d    = '0;
    ptr_d    = ptr_q;
    pick_v_s = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      idx_w    = {1'b0, ptr_q} + (PW+1)'(i);
      idx_w    = (idx_w >= (PW+1)'(N_REQ)) ? idx_w - (PW+1)'(N_REQ) : idx_w;
      nxt_w    = idx_w + (PW+1)'(1);
      nxt_w    = (nxt_w >= (PW+1)'(N_REQ)) ? (PW+1)'(0) : nxt_w;
      hit_w    = ~pick_v_s & elig_s[idx_w[PW-1:0]];
      gnt_d    = hit_w ? (N_REQ'(1'b1) << idx_w[PW-1:0]) : gnt_d;
      ptr_d    = hit_w ? nxt_w[PW-1:0] : ptr_d;
      pick_v_s = pick_v_s | hit_w;
    end
  end

  // Seeding/warm-up/serve sequencer; every output is registered here.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= START_ST;
      cnt_q   <= WARM_CNT;
      s_q     <= SEED;
      ptr_q   <= '0;
      gnt_q   <= '0;
      rnd_q   <= 32'h0;
      busy_q  <= WARM_EN;
    end else if (seed_load) begin
      // An all-zero seed would lock the LFSR, so substitute SEED.
      state_q <= START_ST;
      cnt_q   <= WARM_CNT;
      s_q     <= (seed_in == 32'h0) ? SEED : seed_in;
      gnt_q   <= '0;
      busy_q  <= WARM_EN;
    end else begin
      case (state_q)
        ST_WARM: begin
          gnt_q <= '0;
          s_q   <= lfsr_next(s_q);
          cnt_q <= cnt_q - 8'd1;
          if (cnt_q <= 8'd1) begin
            state_q <= ST_SERVE;
            busy_q  <= 1'b0;
          end else begin
            state_q <= ST_WARM;
            busy_q  <= 1'b1;
          end
        end
        ST_SERVE: begin
          busy_q <= 1'b0;
          gnt_q  <= gnt_d;
          if (pick_v_s) begin
            rnd_q <= s_q;
            s_q   <= lfsr_next(s_q);
            ptr_q <= ptr_d;
          end else begin
            rnd_q <= rnd_q;
            s_q   <= s_q;
            ptr_q <= ptr_q;
          end
        end
        default: begin
          state_q <= START_ST;
          cnt_q   <= WARM_CNT;
          gnt_q   <= '0;
          busy_q  <= WARM_EN;
        end
      endcase
    end
  end

  assign gnt      = gnt_q;
  assign rnd_data = rnd_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_lfsr_rng_arbiter.sv
// Bench for lfsr_rng_arbiter: directed vector table on a no-warm-up instance, hand sequences
// on a default warm-up instance, and a random-traffic scoreboard.
module tb_lfsr_rng_arbiter;
  localparam int N = 4;
  localparam logic [31:0] SEED = 32'h12345678;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          a_reset, a_seed_load, a_busy;
  logic [N-1:0]  a_req, a_gnt;
  logic [31:0]   a_seed_in, a_rnd;
  logic          b_reset, b_seed_load, b_busy;
  logic [N-1:0]  b_req, b_gnt;
  logic [31:0]   b_seed_in, b_rnd;

  lfsr_rng_arbiter #(.N_REQ(N), .SEED(SEED), .WARMUP_CYCLES(0)) dut0 (
    .clk(clk), .reset(a_reset), .req(a_req), .gnt(a_gnt), .rnd_data(a_rnd),
    .seed_load(a_seed_load), .seed_in(a_seed_in), .busy(a_busy)
  );

  lfsr_rng_arbiter #(.N_REQ(N)) dut16 (
    .clk(clk), .reset(b_reset), .req(b_req), .gnt(b_gnt), .rnd_data(b_rnd),
    .seed_load(b_seed_load), .seed_in(b_seed_in), .busy(b_busy)
  );

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic         rst;
    logic         sl;
    logic [31:0]  sin;
    logic [N-1:0] req;
    logic [N-1:0] gnt;
    logic [31:0]  rnd;
    logic         busy;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [31:0] ref_next(input logic [31:0] s);
    logic fb;
    fb = s[31] ^ s[21] ^ s[1] ^ s[0];
    return (s << 1) | {31'h0, fb};
  endfunction

  function automatic logic [31:0] ref_adv(input logic [31:0] s, input int steps);
    logic [31:0] v;
    v = s;
    for (int k = 0; k < steps; k++) v = ref_next(v);
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic rst, input logic sl, input logic [31:0] sin,
                     input logic [N-1:0] req, input logic [N-1:0] gnt, input logic [31:0] rnd);
    vec_t v;
    v.rst = rst; v.sl = sl; v.sin = sin; v.req = req; v.gnt = gnt; v.rnd = rnd; v.busy = 1'b0;
    vecs.push_back(v);
  endtask

  // Starting just after a reset/reseed edge with b_req held, count busy cycles then check the first word.
  task automatic warm_measure(input string tag, input logic [31:0] start);
    int busy_cnt;
    int guard;
    busy_cnt = b_busy ? 1 : 0;
    guard = 0;
    while (b_busy && guard < 64) begin
      tick();
      guard++;
      if (b_busy) begin
        busy_cnt++;
        check({tag, " gnt while busy"}, 32'(b_gnt), 32'h0);
      end
    end
    check({tag, " busy cycles"}, 32'(busy_cnt), 32'd16);
    check({tag, " gnt at busy fall"}, 32'(b_gnt), 32'h0);
    tick();
    check({tag, " first gnt"}, 32'(b_gnt), 32'h1);
    check({tag, " first word"}, b_rnd, ref_adv(start, 16));
  endtask

  initial begin
    a_reset = 1'b1; a_seed_load = 1'b0; a_seed_in = 32'h0; a_req = '0;
    b_reset = 1'b1; b_seed_load = 1'b0; b_seed_in = 32'h0; b_req = '0;

    //   rst   sl    seed_in        req      gnt      rnd
    add(1'b1, 1'b0, 32'h0,        4'b0000, 4'b0000, 32'h00000000);
    add(1'b0, 1'b0, 32'h0,        4'b0001, 4'b0001, 32'h12345678);
    add(1'b0, 1'b0, 32'h0,        4'b0000, 4'b0000, 32'h12345678);
    add(1'b0, 1'b0, 32'h0,        4'b0001, 4'b0001, 32'h2468ACF1);
    add(1'b0, 1'b0, 32'h0,        4'b0000, 4'b0000, 32'h2468ACF1);
    add(1'b0, 1'b0, 32'h0,        4'b0001, 4'b0001, 32'h48D159E2);
    add(1'b0, 1'b0, 32'h0,        4'b0000, 4'b0000, 32'h48D159E2);
    add(1'b1, 1'b0, 32'h0,        4'b1111, 4'b0000, 32'h00000000);
    add(1'b0, 1'b0, 32'h0,        4'b1111, 4'b0001, 32'h12345678);
    add(1'b0, 1'b0, 32'h0,        4'b1111, 4'b0010, 32'h2468ACF1);
    add(1'b0, 1'b0, 32'h0,        4'b1111, 4'b0100, 32'h48D159E2);
    add(1'b0, 1'b0, 32'h0,        4'b1111, 4'b1000, 32'h91A2B3C5);
    add(1'b0, 1'b0, 32'h0,        4'b1111, 4'b0001, 32'h2345678B);
    add(1'b0, 1'b0, 32'h0,        4'b1111, 4'b0010, 32'h468ACF16);
    add(1'b1, 1'b0, 32'h0,        4'b1111, 4'b0000, 32'h00000000);
    add(1'b0, 1'b0, 32'h0,        4'b1111, 4'b0001, 32'h12345678);
    add(1'b0, 1'b0, 32'h0,        4'b0000, 4'b0000, 32'h12345678);
    add(1'b0, 1'b1, 32'h0,        4'b0100, 4'b0000, 32'h12345678);
    add(1'b0, 1'b0, 32'h0,        4'b0100, 4'b0100, 32'h12345678);
    add(1'b0, 1'b0, 32'h0,        4'b0000, 4'b0000, 32'h12345678);
    add(1'b0, 1'b1, 32'hDEADBEEF, 4'b0000, 4'b0000, 32'h12345678);
    add(1'b0, 1'b0, 32'h0,        4'b1111, 4'b1000, 32'hDEADBEEF);
    add(1'b0, 1'b0, 32'h0,        4'b1111, 4'b0001, 32'hBD5B7DDE);
    add(1'b0, 1'b0, 32'h0,        4'b0000, 4'b0000, 32'hBD5B7DDE);
    add(1'b0, 1'b0, 32'h0,        4'b0010, 4'b0010, 32'h7AB6FBBC);
    add(1'b0, 1'b0, 32'h0,        4'b0010, 4'b0000, 32'h7AB6FBBC);
    add(1'b0, 1'b0, 32'h0,        4'b0010, 4'b0010, 32'hF56DF779);

    foreach (vecs[i]) begin
      a_reset = vecs[i].rst; a_seed_load = vecs[i].sl; a_seed_in = vecs[i].sin; a_req = vecs[i].req;
      tick();
      check($sformatf("v%0d gnt", i), 32'(a_gnt), 32'(vecs[i].gnt));
      check($sformatf("v%0d rnd", i), a_rnd, vecs[i].rnd);
      check($sformatf("v%0d busy", i), 32'(a_busy), 32'(vecs[i].busy));
    end
    a_reset = 1'b0; a_seed_load = 1'b0; a_req = '0;

    // Default warm-up: reset, then req[0] held through warm-up.
    b_reset = 1'b1; b_req = 4'b0001;
    tick();
    b_reset = 1'b0;
    check("w rst busy", 32'(b_busy), 32'h1);
    check("w rst gnt", 32'(b_gnt), 32'h0);
    check("w rst rnd", b_rnd, 32'h0);
    warm_measure("w boot", SEED);

    // Reset after a grant clears outputs, then reset again mid warm-up.
    b_reset = 1'b1;
    tick();
    b_reset = 1'b0;
    check("w rst2 gnt", 32'(b_gnt), 32'h0);
    check("w rst2 rnd", b_rnd, 32'h0);
    check("w rst2 busy", 32'(b_busy), 32'h1);
    repeat (5) tick();
    b_reset = 1'b1;
    tick();
    b_reset = 1'b0;
    warm_measure("w midrst", SEED);

    // Seed load during serve restarts warm-up from the new seed.
    b_req = '0;
    tick();
    b_seed_load = 1'b1; b_seed_in = 32'hCAFEF00D; b_req = 4'b0001;
    tick();
    b_seed_load = 1'b0;
    check("w seed gnt", 32'(b_gnt), 32'h0);
    check("w seed busy", 32'(b_busy), 32'h1);
    warm_measure("w seed", 32'hCAFEF00D);
    b_req = '0;

    // Random traffic against a scoreboard on the no-warm-up instance.
    begin
      logic [31:0]  m_s, m_rnd;
      logic [N-1:0] m_gnt, elig, prev_req;
      int           m_ptr, idx, max_wait;
      int           waited[N];
      bit           found;
      a_reset = 1'b1;
      tick();
      a_reset = 1'b0;
      m_s = SEED; m_rnd = 32'h0; m_gnt = '0; m_ptr = 0; max_wait = 0;
      for (int j = 0; j < N; j++) waited[j] = 0;
      for (int c = 0; c < 10000; c++) begin
        a_req = N'($urandom_range(0, 15));
        prev_req = a_req;
        elig = a_req & ~m_gnt;
        found = 1'b0;
        m_gnt = '0;
        for (int k = 0; k < N; k++) begin
          idx = (m_ptr + k) % N;
          if (!found && elig[idx]) begin
            found = 1'b1;
            m_gnt[idx] = 1'b1;
            m_rnd = m_s;
            m_s = ref_next(m_s);
            m_ptr = (idx + 1) % N;
          end
        end
        tick();
        check($sformatf("r%0d gnt", c), 32'(a_gnt), 32'(m_gnt));
        check($sformatf("r%0d rnd", c), a_rnd, m_rnd);
        check($sformatf("r%0d onehot", c), 32'($onehot0(a_gnt)), 32'h1);
        check($sformatf("r%0d gnt w/o req", c), 32'(a_gnt & ~prev_req), 32'h0);
        for (int j = 0; j < N; j++) begin
          if (a_gnt[j] || !prev_req[j]) waited[j] = 0;
          else if (a_gnt != '0) waited[j]++;
          if (waited[j] > max_wait) max_wait = waited[j];
        end
      end
      check("r max wait within N", 32'(max_wait <= N), 32'h1);
      a_req = '0;
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/lfsr_rng_arbiter.md
Name: lfsr_rng_arbiter

Overview:
- Owns a single 32-bit Fibonacci LFSR random source and shares it among N requesters using round-robin arbitration.
- Each grant delivers one 32-bit word, and the LFSR advances exactly one step per word issued, so no two requesters ever receive the same word.
- Also sequences seeding: reset or a seed load is followed by a warm-up run before any word is served.
- Sits between the random-number consumers and the generator core.

Parameters:
- N_REQ, 4, number of requesters (2..16).
- SEED, 32'h12345678, reset seed and substitute for an all-zero loaded seed.
- WARMUP_CYCLES, 16, LFSR steps discarded after reset or seed load (0..255; 0 = no warm-up).

Ports:
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- req  in  N_REQ  per-requester level request, one bit per requester.
- gnt  out  N_REQ  one-hot grant, one-cycle pulse.
- rnd_data  out  32  random word, valid when any gnt bit is high.
- seed_load  in  1  one-cycle strobe; load seed_in and restart warm-up.
- seed_in  in  32  seed value captured on seed_load.
- busy  out  1  high during warm-up; no grants are issued while high.

Behaviour:
- LFSR polynomial: x^32+x^22+x^2+x+1.
  - fb = s[31]^s[21]^s[1]^s[0].
  - next = {s[30:0], fb}.
  - The all-zero state is unreachable.
- Reset (synchronous, highest priority):
  - s <= SEED; gnt <= 0; rnd_data <= 0; rr pointer <= 0 (req[0] highest priority).
  - busy <= (WARMUP_CYCLES != 0); warm-up counter <= WARMUP_CYCLES.
  - Reset mid-warm-up or mid-grant aborts the operation; gnt is 0 on the following cycle.
- States:
  - WARM: busy=1. s advances one step per cycle while the counter decrements. When the counter reaches 1 (or immediately if WARMUP_CYCLES=0), go to SERVE with busy=0 on the next cycle. The req input is ignored in WARM.
  - SERVE: busy=0. Each cycle, eligible = req & ~gnt (a requester whose gnt is currently high is masked for that cycle).
    - If eligible is nonzero, pick the first eligible index at or after the rr pointer, wrapping modulo N_REQ.
    - On that clock edge: gnt <= onehot(pick); rnd_data <= s; s <= next(s); ptr <= (pick+1) mod N_REQ.
    - Otherwise gnt <= 0, s holds, and rnd_data holds its last value.
- Latency and throughput:
  - gnt/rnd_data appear the cycle after req is sampled.
  - Throughput is one word per cycle across requesters and at most one word per two cycles per requester.
  - A requester holding req continuously is re-granted after the cycle its gnt is high, subject to round-robin order.
- Seed load:
  - If seed_load is high in any state: s <= (seed_in==0 ? SEED : seed_in); counter <= WARMUP_CYCLES; gnt <= 0; next state is WARM (or SERVE if WARMUP_CYCLES=0).
  - seed_load takes priority over a simultaneous request; that request is not granted and remains pending.
  - The rr pointer is not reset by seed_load.
- No requesters: s does not advance in SERVE (advance only on grant), so the sequence is deterministic per request count.
- gnt is always one-hot or zero, and is never nonzero while busy=1.

Test Plan:
- WARMUP_CYCLES=0: after reset, single req[0] held for 1 cycle -> gnt=0001 next cycle, rnd_data=0x12345678. Repeat -> rnd_data=0x2468ACF1, then 0x48D159E2.
- WARMUP_CYCLES=0, N_REQ=4: req=1111 held continuously -> grants cycle 0001,0010,0100,1000,0001 on consecutive cycles. rnd_data follows the LFSR sequence 0x12345678, 0x2468ACF1, 0x48D159E2, ... with no word repeated.
- Default WARMUP_CYCLES=16: after reset, req=0001 held -> busy=1 for 16 cycles, no gnt. The first gnt comes the cycle after busy falls, with rnd_data equal to SEED advanced 16 steps (bench reference model).
- seed_load=1, seed_in=0, with req[2] asserted in the same cycle (WARMUP_CYCLES=0) -> no gnt that cycle. Next grant is to req[2] with rnd_data=0x12345678 (zero-seed substitution).
- Reset asserted during warm-up and during a grant burst -> gnt=0 and rnd_data=0 the next cycle; the LFSR restarts from SEED; the pointer returns to req[0].
- Random req traffic for 10k cycles -> gnt is always one-hot/zero, gnt is only ever asserted for a requester whose req was high the previous cycle, every issued word matches the model, and no requester waits more than N_REQ grants.
